ttt_cpu_player: RTL and testbench
=================================

TTT_CPU_PLAYER -- requirements
Module: ttt_cpu_player

Interface
REQ-001 clk  in  1  system clock; all state changes on posedge clk.
REQ-002 rst  in  1  reset, synchronous, active-low.
REQ-003 board  in  18  board snapshot; cell i (0..8, row-major 0 1 2/3 4 5/6 7 8) at bits [2i+1:2i]; 00 empty, 01 player 1, 10 player 2, 11 occupied/neutral.
REQ-004 me  in  1  CPU identity: 0 = player 1 (code 01), 1 = player 2 (code 10).
REQ-005 req  in  1  move request; accepted only on a posedge where state is IDLE and rst=1.
REQ-006 busy  out  1  high from the edge after acceptance until the handshake edge.
REQ-007 mv_valid  out  1  move offer valid.
REQ-008 mv_idx  out  4  chosen cell 0..8; 4'hF when no_move.
REQ-009 mv_onehot  out  9  one-hot of mv_idx; all-zero when no_move.
REQ-010 no_move  out  1  qualifies mv_valid: board had no empty cell.
REQ-011 mv_ready  in  1  consumer accepts offer when high with mv_valid.

Function
REQ-012 States SHALL be IDLE, SCAN_WIN, SCAN_BLOCK, PICK, OFFER; all outputs registered.
REQ-013 On acceptance, board and me SHALL be latched; later changes to board/me SHALL be ignored until IDLE.
REQ-014 Acceptance SHALL set state SCAN_WIN, line counter 0, busy=1.
REQ-015 Line order SHALL be fixed: 0:{0,1,2} 1:{3,4,5} 2:{6,7,8} 3:{0,3,6} 4:{1,4,7} 5:{2,5,8} 6:{0,4,8} 7:{2,4,6}.
REQ-016 SCAN_WIN SHALL evaluate one line per cycle; hit = exactly two cells equal own code and third cell 00; on hit, next state OFFER with mv_idx = empty cell.
REQ-017 After line 7 without hit, SCAN_WIN SHALL go to SCAN_BLOCK with counter 0; SCAN_BLOCK is identical using the opponent code.
REQ-018 After SCAN_BLOCK line 7 without hit, state SHALL go to PICK; PICK SHALL choose first empty cell in order 4,0,2,6,8,1,3,5,7 in one cycle, then OFFER.
REQ-019 If no cell is 00, PICK SHALL offer no_move=1, mv_idx=4'hF, mv_onehot=0.
REQ-020 Lowest-index hit line SHALL win; win scan SHALL take priority over block.
REQ-021 Latency: win hit on line k -> mv_valid high after edge E0+k+1 (E0 = acceptance edge); block hit on line k -> E0+9+k; PICK -> E0+17 (maximum).
REQ-022 In OFFER, mv_valid, mv_idx, mv_onehot, no_move SHALL hold stable until an edge with mv_ready=1.
REQ-023 Handshake edge SHALL return to IDLE, clear mv_valid, no_move, busy; mv_idx/mv_onehot may hold last value.
REQ-024 req while busy SHALL be ignored (not queued); a new request is accepted no earlier than the edge after the handshake edge.
REQ-025 Cells coded 11 SHALL count as occupied and match neither own nor opponent.
REQ-026 mv_ready while mv_valid=0 SHALL have no effect.

Reset
REQ-027 rst=0 at a posedge SHALL force IDLE, counter 0, busy=0, mv_valid=0, no_move=0, mv_idx=0, mv_onehot=0, latched board 0, regardless of state (including mid-scan or mid-offer).
REQ-028 rst SHALL take priority over req and mv_ready on the same edge.

Structure
REQ-029 Shared package tictactoe_pkg SHALL hold cell codes (EMPTY/P1/P2), state enum, 8-entry line table, 9-entry pick-priority table.
REQ-030 One sub-module ttt_line_eval (combinational: three cell codes + target code -> hit, empty cell index) SHALL be instantiated once, fed by the counter-selected line.

Verification
REQ-031 Empty board 18'h00000, me=1, req pulse -> mv_valid at E0+17, mv_idx=4, mv_onehot=9'h010, no_move=0.
REQ-032 board=18'h0014A (P2 at 0,1; P1 at 3,4), me=1 -> win line 0, mv_idx=2 at E0+1.
REQ-033 board=18'h00109 (P1 at 0,4; P2 at 1), me=1 -> block line 6, mv_idx=8 at E0+15.
REQ-034 board=18'h15555 (all P1), me=0 -> at E0+17 mv_valid=1, no_move=1, mv_idx=4'hF, mv_onehot=0.
REQ-035 Case REQ-032 with mv_ready=0 for 5 cycles, req pulsed and board changed during OFFER -> outputs stable, single handshake, busy falls on handshake edge, no second offer.
REQ-036 rst=0 at E0+5 during scan -> next edge busy=0, mv_valid=0; fresh req with 18'h00000 then yields mv_idx=4 at E0'+17.

Source files
------------

// File: rtl/tictactoe_pkg.sv
// Shared definitions for the tic-tac-toe CPU player.
//   cell codes  : EMPTY / P1 / P2 / NEUTRAL (2 bits per cell)
//   state_t     : move-search FSM states
//   LINE_TBL    : the 8 winning lines, scanned in this fixed order
//   PICK_ORDER  : fallback cell preference (centre, corners, edges)
//   cell_at()   : extract one cell code from an 18-bit board snapshot
package tictactoe_pkg;

    typedef logic [1:0] cell_t;

    localparam cell_t EMPTY   = 2'b00;
    localparam cell_t P1      = 2'b01;
    localparam cell_t P2      = 2'b10;
    localparam cell_t NEUTRAL = 2'b11;

    localparam logic [3:0] NO_MOVE_IDX = 4'hF;

    typedef enum logic [2:0] {
        IDLE,
        SCAN_WIN,
        SCAN_BLOCK,
        PICK,
        OFFER
    } state_t;

    localparam logic [3:0] LINE_TBL [8][3] = '{
        '{4'd0, 4'd1, 4'd2},
        '{4'd3, 4'd4, 4'd5},
        '{4'd6, 4'd7, 4'd8},
        '{4'd0, 4'd3, 4'd6},
        '{4'd1, 4'd4, 4'd7},
        '{4'd2, 4'd5, 4'd8},
        '{4'd0, 4'd4, 4'd8},
        '{4'd2, 4'd4, 4'd6}
    };

    localparam logic [3:0] PICK_ORDER [9] = '{
        4'd4, 4'd0, 4'd2, 4'd6, 4'd8, 4'd1, 4'd3, 4'd5, 4'd7
    };

    function automatic cell_t cell_at(input logic [17:0] b, input logic [3:0] idx);
        return b[{idx, 1'b0} +: 2];
    endfunction

endpackage

// File: rtl/ttt_line_eval.sv
// Combinational evaluation of one board line.
//   c0,c1,c2 : the three cell codes of the line, in line-table order
//   target   : code being looked for (own code to win, opponent to block)
//   hit      : exactly two cells hold target and the third is empty
//   slot     : position (0..2) of the empty cell within the line when hit
module ttt_line_eval
    import tictactoe_pkg::*;
(
    input  cell_t      c0,
    input  cell_t      c1,
    input  cell_t      c2,
    input  cell_t      target,
    output logic       hit,
    output logic [1:0] slot
);

    // target is never EMPTY, so a cell can't be both "target" and "empty";
    // NEUTRAL cells fail both tests and therefore never complete a line.
    always_comb begin
        hit  = 1'b0;
        slot = 2'd0;
        if (c0 == EMPTY && c1 == target && c2 == target) begin
            hit  = 1'b1;
            slot = 2'd0;
        end else if (c0 == target && c1 == EMPTY && c2 == target) begin
            hit  = 1'b1;
            slot = 2'd1;
        end else if (c0 == target && c1 == target && c2 == EMPTY) begin
            hit  = 1'b1;
            slot = 2'd2;
        end
    end

endmodule

// File: rtl/ttt_cpu_player.sv
// Tic-tac-toe CPU move chooser.
// On an accepted request the board is latched and searched one line per
// cycle: first for a winning move, then for a block, then a fixed-priority
// fallback pick. The result is offered with a valid/ready handshake.
//   clk, rst   : clock, synchronous active-low reset
//   board, me  : board snapshot (2 bits/cell) and CPU identity (0=P1, 1=P2)
//   req        : move request, taken only when idle
//   busy       : request in progress (acceptance edge .. handshake edge)
//   mv_valid   : offer valid; mv_idx / mv_onehot / no_move describe it
//   mv_ready   : consumer accepts the offer
module ttt_cpu_player
    import tictactoe_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [17:0] board,
    input  logic        me,
    input  logic        req,
    output logic        busy,
    output logic        mv_valid,
    output logic [3:0]  mv_idx,
    output logic [8:0]  mv_onehot,
    output logic        no_move,
    input  logic        mv_ready
);

    state_t      state_q, state_d;
    logic [2:0]  ctr_q, ctr_d;
    logic [17:0] board_q, board_d;
    logic        me_q, me_d;
    logic        busy_q, busy_d;
    logic        valid_q, valid_d;
    logic [3:0]  idx_q, idx_d;
    logic [8:0]  onehot_q, onehot_d;
    logic        nm_q, nm_d;

    cell_t       own_code, opp_code, target;
    logic        hit;
    logic [1:0]  slot;
    logic [3:0]  pick_idx;
    logic        pick_found;

    assign own_code = me_q ? P2 : P1;
    assign opp_code = me_q ? P1 : P2;
    assign target   = (state_q == SCAN_BLOCK) ? opp_code : own_code;

    ttt_line_eval u_line_eval (
        .c0     (cell_at(board_q, LINE_TBL[ctr_q][0])),
        .c1     (cell_at(board_q, LINE_TBL[ctr_q][1])),
        .c2     (cell_at(board_q, LINE_TBL[ctr_q][2])),
        .target (target),
        .hit    (hit),
        .slot   (slot)
    );

    // Walk the priority list backwards so the earliest empty entry wins.
    always_comb begin
        pick_idx   = NO_MOVE_IDX;
        pick_found = 1'b0;
        for (int i = 8; i >= 0; i--) begin
            if (cell_at(board_q, PICK_ORDER[i]) == EMPTY) begin
                pick_idx   = PICK_ORDER[i];
                pick_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ctr_d    = ctr_q;
        board_d  = board_q;
        me_d     = me_q;
        busy_d   = busy_q;
        valid_d  = valid_q;
        idx_d    = idx_q;
        onehot_d = onehot_q;
        nm_d     = nm_q;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    board_d = board;
                    me_d    = me;
                    ctr_d   = 3'd0;
                    busy_d  = 1'b1;
                    state_d = SCAN_WIN;
                end
            end
            SCAN_WIN, SCAN_BLOCK: begin
                if (hit) begin
                    idx_d    = LINE_TBL[ctr_q][slot];
                    onehot_d = 9'd1 << LINE_TBL[ctr_q][slot];
                    nm_d     = 1'b0;
                    valid_d  = 1'b1;
                    state_d  = OFFER;
                end else if (ctr_q == 3'd7) begin
                    ctr_d   = 3'd0;
                    state_d = (state_q == SCAN_WIN) ? SCAN_BLOCK : PICK;
                end else begin
                    ctr_d = ctr_q + 3'd1;
                end
            end
            PICK: begin
                idx_d    = pick_idx;
                onehot_d = pick_found ? (9'd1 << pick_idx) : 9'd0;
                nm_d     = ~pick_found;
                valid_d  = 1'b1;
                state_d  = OFFER;
            end
            OFFER: begin
                if (mv_ready) begin
                    valid_d = 1'b0;
                    nm_d    = 1'b0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            ctr_q    <= 3'd0;
            board_q  <= 18'd0;
            me_q     <= 1'b0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            idx_q    <= 4'd0;
            onehot_q <= 9'd0;
            nm_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            ctr_q    <= ctr_d;
            board_q  <= board_d;
            me_q     <= me_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
            idx_q    <= idx_d;
            onehot_q <= onehot_d;
            nm_q     <= nm_d;
        end
    end

    assign busy      = busy_q;
    assign mv_valid  = valid_q;
    assign mv_idx    = idx_q;
    assign mv_onehot = onehot_q;
    assign no_move   = nm_q;

endmodule

// File: tb/tb_ttt_cpu_player.sv
module tb_ttt_cpu_player;

    logic        clk = 1'b0;
    logic        rst;
    logic [17:0] board;
    logic        me;
    logic        req;
    logic        busy;
    logic        mv_valid;
    logic [3:0]  mv_idx;
    logic [8:0]  mv_onehot;
    logic        no_move;
    logic        mv_ready;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 0;

    always #5 clk = ~clk;

    ttt_cpu_player dut (
        .clk       (clk),
        .rst       (rst),
        .board     (board),
        .me        (me),
        .req       (req),
        .busy      (busy),
        .mv_valid  (mv_valid),
        .mv_idx    (mv_idx),
        .mv_onehot (mv_onehot),
        .no_move   (no_move),
        .mv_ready  (mv_ready)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: search the game rules directly and report the chosen cell
    // together with how many edges after acceptance the offer appears.
    function automatic void model_move(input logic [17:0] b, input logic me_i,
                                       output int idx, output bit nm, output int lat);
        int lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                             '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
        int order [9] = '{4,0,2,6,8,1,3,5,7};
        int own, tgt, n_t, n_e, e_pos;
        own = me_i ? 2 : 1;
        for (int pass = 0; pass < 2; pass++) begin
            tgt = (pass == 0) ? own : 3 - own;
            for (int l = 0; l < 8; l++) begin
                n_t = 0; n_e = 0; e_pos = 0;
                for (int j = 0; j < 3; j++) begin
                    if (int'(b[2*lines[l][j] +: 2]) == tgt) n_t++;
                    if (b[2*lines[l][j] +: 2] == 2'b00) begin n_e++; e_pos = lines[l][j]; end
                end
                if (n_t == 2 && n_e == 1) begin
                    idx = e_pos; nm = 0; lat = pass * 8 + l + 1;
                    return;
                end
            end
        end
        lat = 17; idx = 15; nm = 1;
        for (int k = 8; k >= 0; k--)
            if (b[2*order[k] +: 2] == 2'b00) begin idx = order[k]; nm = 0; end
    endfunction

    // Transaction-level model: busy from acceptance, offer after the rule
    // latency, ends on the first edge with mv_ready while the offer is up.
    bit m_busy, m_valid, m_nm;
    int m_t, m_lat, m_idx;

    always @(posedge clk) begin
        if (!rst) begin
            m_busy = 0; m_valid = 0; m_t = 0;
        end else if (m_busy) begin
            if (m_valid && mv_ready) begin
                m_busy = 0; m_valid = 0;
            end else begin
                m_t++;
                if (m_t >= m_lat) m_valid = 1;
            end
        end else if (req) begin
            model_move(board, me, m_idx, m_nm, m_lat);
            m_busy = 1; m_t = 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", 32'(busy), 32'(m_busy));
            chk("mv_valid", 32'(mv_valid), 32'(m_valid));
            chk("no_move", 32'(no_move), 32'(m_valid & m_nm));
            if (m_valid) begin
                chk("mv_idx", 32'(mv_idx), 32'(m_idx));
                chk("mv_onehot", 32'(mv_onehot), m_nm ? 32'd0 : (32'd1 << m_idx));
            end
        end
    end

    // Issue one request, check offer latency and contents against literals,
    // optionally stall the consumer and disturb inputs, then handshake.
    task automatic run_case(input string name, input logic [17:0] b, input logic me_i,
                            input int exp_idx, input bit exp_nm, input int exp_lat,
                            input int hold, input bit disturb);
        int n;
        @(negedge clk);
        board = b; me = me_i; req = 1'b1;
        @(negedge clk);            // acceptance edge E0 has passed
        req = 1'b0;
        n = 0;
        while (!mv_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({name, " latency"}, 32'(n), 32'(exp_lat));
        chk({name, " idx"}, 32'(mv_idx), 32'(exp_idx));
        chk({name, " no_move"}, 32'(no_move), 32'(exp_nm));
        chk({name, " onehot"}, 32'(mv_onehot), exp_nm ? 32'd0 : (32'd1 << exp_idx));
        for (int c = 0; c < hold; c++) begin
            if (disturb && c == 1) begin req = 1'b1; board = ~b; me = ~me_i; end
            if (disturb && c == 2) req = 1'b0;
            @(negedge clk);
            chk({name, " held idx"}, 32'(mv_idx), 32'(exp_idx));
            chk({name, " held valid"}, 32'(mv_valid), 32'd1);
        end
        req = 1'b0;
        mv_ready = 1'b1;
        @(negedge clk);            // handshake edge has passed
        mv_ready = 1'b0;
        chk({name, " busy after hs"}, 32'(busy), 32'd0);
        chk({name, " valid after hs"}, 32'(mv_valid), 32'd0);
        repeat (3) begin
            @(negedge clk);
            chk({name, " no 2nd offer"}, 32'(mv_valid), 32'd0);
        end
    endtask

    initial begin
        rst = 1'b0; req = 1'b0; mv_ready = 1'b0; board = '0; me = 1'b0;
        repeat (3) @(negedge clk);
        chk_en = 1;
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst valid", 32'(mv_valid), 32'd0);
        chk("rst idx", 32'(mv_idx), 32'd0);
        chk("rst onehot", 32'(mv_onehot), 32'd0);
        chk("rst no_move", 32'(no_move), 32'd0);
        rst = 1'b1;

        // mv_ready with no offer pending must do nothing
        mv_ready = 1'b1;
        @(negedge clk);
        mv_ready = 1'b0;
        chk("idle ready busy", 32'(busy), 32'd0);

        run_case("empty",     18'h00000, 1'b1, 4,  0, 17, 0, 0);
        run_case("win0",      18'h0014A, 1'b1, 2,  0, 1,  0, 0);
        run_case("block6",    18'h00109, 1'b1, 8,  0, 15, 0, 0);
        run_case("full",      18'h15555, 1'b0, 15, 1, 17, 0, 0);
        run_case("win7",      18'h00110, 1'b0, 6,  0, 8,  0, 0);
        run_case("win>blk",   18'h00285, 1'b0, 2,  0, 1,  0, 0);
        run_case("neutral",   18'h0000F, 1'b0, 4,  0, 17, 0, 0);
        run_case("ctr_taken", 18'h00300, 1'b1, 0,  0, 17, 0, 0);
        run_case("stall",     18'h0014A, 1'b1, 2,  0, 1,  5, 1);

        // reset in the middle of a scan
        @(negedge clk);
        board = 18'h00000; me = 1'b1; req = 1'b1;
        @(negedge clk);            // after E0
        req = 1'b0;
        repeat (4) @(negedge clk); // after E0+4
        rst = 1'b0;
        @(negedge clk);            // after E0+5
        chk("midrst busy", 32'(busy), 32'd0);
        chk("midrst valid", 32'(mv_valid), 32'd0);
        chk("midrst idx", 32'(mv_idx), 32'd0);
        chk("midrst onehot", 32'(mv_onehot), 32'd0);
        rst = 1'b1;
        run_case("after_rst", 18'h00000, 1'b1, 4, 0, 17, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
